gcn_transform_ctrl: RTL and testbench
=====================================

Name: gcn_transform_ctrl

Overview:
Parametrised sequencer for the GCN feature x weight transformation stage. It loads a group of LANES weight columns into the scratch pad, then streams every feature row through LANES parallel MACs. Each row's LANES products are written to the FM*WM product memory through a valid/ready handshake, and the sequence repeats for each column group. Row and column counters are internal, replacing the externally-counted single-column controller.

Parameters:
FEATURE_ROWS, 6, feature matrix rows (>=1)
WEIGHT_COLS, 3, weight matrix columns (>=1)
LANES, 1, weight columns processed in parallel per pass (1..WEIGHT_COLS)
MAC_LATENCY, 1, cycles from feature read to product valid (>=1)
ROW_W, max(1,$clog2(FEATURE_ROWS)), row address width
COL_W, max(1,$clog2(WEIGHT_COLS)), column address width
LANE_W, max(1,$clog2(LANES)), lane index width

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
start  in  1  level request; sampled only in IDLE
prod_wr_ready  in  1  product memory accepts write
weight_rd_en  out  1  read weight memory
weight_col_addr  out  COL_W  weight column being read
scratch_we  out  1  write scratch pad lane
scratch_lane  out  LANE_W  scratch pad lane written
feature_rd_en  out  1  read feature memory
feature_row_addr  out  ROW_W  feature row being read
prod_wr_en  out  1  product write valid
prod_row_addr  out  ROW_W  product row
prod_col_base  out  COL_W  column of lane 0
prod_lane_mask  out  LANES  lane k valid when col_base+k < WEIGHT_COLS
busy  out  1  high in every state except IDLE and DONE
done  out  1  high in DONE only

Behaviour:
- Reset (async, any state): state=IDLE; row, col_base, lane and latency counters = 0; all outputs 0.
- Outputs are Moore-decoded from state and registered counters; addresses reflect current counter values.
- IDLE: on start=1, clear counters and go to LOAD_W. Otherwise stay.
- LOAD_W: weight_rd_en=scratch_we=1; weight_col_addr=col_base+lane; scratch_lane=lane; one cycle per lane.
  - If lane==LANES-1 or col_base+lane==WEIGHT_COLS-1: lane<=0, go to READ_F.
  - Otherwise lane++.
  - Out-of-range lanes in a partial final group are never loaded.
- READ_F: feature_rd_en=1, feature_row_addr=row; go to MAC_WAIT.
- MAC_WAIT: stay exactly MAC_LATENCY cycles, then go to WRITE.
- WRITE: prod_wr_en=1, prod_row_addr=row, prod_col_base=col_base, prod_lane_mask as defined.
  - Hold all of these stable while prod_wr_ready=0. Transfer occurs on the cycle with prod_wr_en & prod_wr_ready.
  - On transfer, if row<FEATURE_ROWS-1: row++, go to READ_F.
  - On transfer, if row==FEATURE_ROWS-1 and col_base+LANES>=WEIGHT_COLS: go to DONE.
  - On transfer, if row==FEATURE_ROWS-1 otherwise: row<=0, col_base+=LANES, go to LOAD_W.
- DONE: done=1; stay while start=1; go to IDLE on start=0. A held start never retriggers.
- start during busy is ignored.
- Cycles from LOAD_W entry to DONE entry with ready always high = WEIGHT_COLS + ceil(WEIGHT_COLS/LANES)*FEATURE_ROWS*(2+MAC_LATENCY).
- Counter arithmetic never wraps. col_base+lane is compared at COL_W+1 bits.

Optional Feature:
GCN_TRANSFORM_ABORT_EN:
- Defined: adds input abort (1 bit). abort=1 in any busy state forces IDLE next cycle and clears all counters. Outputs are 0 from that edge, and done is never asserted for the aborted run. abort has priority over every transition, including WRITE transfer. abort is ignored in IDLE and DONE.
- Undefined: no abort port; behaviour as above.

Test Plan:
- FEATURE_ROWS=6, WEIGHT_COLS=3, LANES=1, MAC_LATENCY=1, ready=1, start pulse -> weight_col_addr 0,1,2 in order; 18 writes with (row, col_base) = (0..5, 0..2); done after exactly 57 cycles from LOAD_W entry.
- LANES=2, same dims -> group 0 loads lanes 0,1 (cols 0,1) with mask 2'b11; group 1 loads only col 2 with mask 2'b01; 12 writes; DONE after 39 cycles.
- LANES=3, ready toggles 0,0,1 during each WRITE -> prod_wr_en and addresses held stable while ready=0; 6 transfers total; rows 0..5 in order.
- start held high through DONE -> done stays 1 and no new LOAD_W; start drops -> IDLE next cycle; new start -> second run has identical address sequence.
- reset asserted mid-WRITE at row 3, col_base 1 -> same cycle all outputs 0 and state IDLE; after release, start -> run restarts from row 0, col 0.
- With GCN_TRANSFORM_ABORT_EN, abort during MAC_WAIT of row 2 -> IDLE next cycle, busy=0, done never asserted; subsequent start completes a full 57-cycle run.

Source files
------------

// File: rtl/gcn_transform_ctrl.sv
// gcn_transform_ctrl
//   Sequencer for the GCN feature x weight transformation stage. For each
//   group of LANES weight columns it loads the columns into the scratch pad
//   (one lane per cycle), then streams every feature row through the LANES
//   parallel MACs and writes each row's products to the product memory.
//   Row, column-group and lane counters are all internal.
//
//   Optional feature macro: GCN_TRANSFORM_ABORT_EN (adds input 'abort').
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   abort               (GCN_TRANSFORM_ABORT_EN only) cancel a busy run
//   start               level request, sampled only in IDLE
//   prod_wr_ready       product memory accepts the write
//   weight_rd_en        weight memory read strobe
//   weight_col_addr     weight column being read
//   scratch_we          scratch pad lane write strobe
//   scratch_lane        scratch pad lane being written
//   feature_rd_en       feature memory read strobe
//   feature_row_addr    feature row being read
//   prod_wr_en          product write valid
//   prod_row_addr       product row
//   prod_col_base       weight column carried by lane 0
//   prod_lane_mask      lane k valid when prod_col_base+k < WEIGHT_COLS
//   busy                high in every state except IDLE and DONE
//   done                high in DONE only
//
// Handshake: a product write transfers on the rising edge where
//   prod_wr_en && prod_wr_ready. While prod_wr_en is high and ready is low,
//   prod_wr_en, prod_row_addr, prod_col_base and prod_lane_mask hold stable;
//   prod_wr_en never drops without a transfer (except on reset/abort).
//
// The FSM state is held in 'state' (type state_t) for hierarchical probing.

module gcn_transform_ctrl #(
  parameter int FEATURE_ROWS = 6,
  parameter int WEIGHT_COLS  = 3,
  parameter int LANES        = 1,
  parameter int MAC_LATENCY  = 1,
  parameter int ROW_W  = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1,
  parameter int COL_W  = (WEIGHT_COLS  > 1) ? $clog2(WEIGHT_COLS)  : 1,
  parameter int LANE_W = (LANES        > 1) ? $clog2(LANES)        : 1
) (
  input  logic              clk,
  input  logic              reset,
`ifdef GCN_TRANSFORM_ABORT_EN
  input  logic              abort,
`endif
  input  logic              start,
  input  logic              prod_wr_ready,
  output logic              weight_rd_en,
  output logic [COL_W-1:0]  weight_col_addr,
  output logic              scratch_we,
  output logic [LANE_W-1:0] scratch_lane,
  output logic              feature_rd_en,
  output logic [ROW_W-1:0]  feature_row_addr,
  output logic              prod_wr_en,
  output logic [ROW_W-1:0]  prod_row_addr,
  output logic [COL_W-1:0]  prod_col_base,
  output logic [LANES-1:0]  prod_lane_mask,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_W   = 3'd1,
    S_READ_F   = 3'd2,
    S_MAC_WAIT = 3'd3,
    S_WRITE    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  // Column arithmetic is done one bit wider than COL_W so col_base+lane and
  // col_base+LANES never wrap before being compared.
  localparam int CW1   = COL_W + 1;
  localparam int LAT_W = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

  localparam logic [CW1-1:0]    LAST_COL  = CW1'(WEIGHT_COLS - 1);
  localparam logic [CW1-1:0]    WCOLS_C   = CW1'(WEIGHT_COLS);
  localparam logic [CW1-1:0]    LANES_C   = CW1'(LANES);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(FEATURE_ROWS - 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [LAT_W-1:0]  LAST_LAT  = LAT_W'(MAC_LATENCY - 1);

  state_t              state, state_nxt;
  logic [ROW_W-1:0]    row, row_nxt;
  logic [COL_W-1:0]    col_base, col_base_nxt;
  logic [LANE_W-1:0]   lane, lane_nxt;
  logic [LAT_W-1:0]    lat, lat_nxt;

  logic [CW1-1:0]      col_lane;   // column loaded by the current lane
  logic [CW1-1:0]      col_end;    // first column of the next group
  logic                abort_hit;

  assign col_lane = {1'b0, col_base} + CW1'(lane);
  assign col_end  = {1'b0, col_base} + LANES_C;

`ifdef GCN_TRANSFORM_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      row      <= '0;
      col_base <= '0;
      lane     <= '0;
      lat      <= '0;
    end else begin
      state    <= state_nxt;
      row      <= row_nxt;
      col_base <= col_base_nxt;
      lane     <= lane_nxt;
      lat      <= lat_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    row_nxt          = row;
    col_base_nxt     = col_base;
    lane_nxt         = lane;
    lat_nxt          = lat;
    weight_rd_en     = 1'b0;
    weight_col_addr  = '0;
    scratch_we       = 1'b0;
    scratch_lane     = '0;
    feature_rd_en    = 1'b0;
    feature_row_addr = '0;
    prod_wr_en       = 1'b0;
    prod_row_addr    = '0;
    prod_col_base    = '0;
    prod_lane_mask   = '0;
    busy             = 1'b0;
    done             = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt    = S_LOAD_W;
          row_nxt      = '0;
          col_base_nxt = '0;
          lane_nxt     = '0;
          lat_nxt      = '0;
        end
      end

      S_LOAD_W: begin
        busy            = 1'b1;
        weight_rd_en    = 1'b1;
        scratch_we      = 1'b1;
        weight_col_addr = COL_W'(col_lane);
        scratch_lane    = lane;
        // A partial final group stops at the last real column.
        if (lane == LAST_LANE || col_lane == LAST_COL) begin
          lane_nxt  = '0;
          state_nxt = S_READ_F;
        end else begin
          lane_nxt = lane + 1'b1;
        end
      end

      S_READ_F: begin
        busy             = 1'b1;
        feature_rd_en    = 1'b1;
        feature_row_addr = row;
        lat_nxt          = '0;
        state_nxt        = S_MAC_WAIT;
      end

      S_MAC_WAIT: begin
        busy = 1'b1;
        if (lat == LAST_LAT) begin
          lat_nxt   = '0;
          state_nxt = S_WRITE;
        end else begin
          lat_nxt = lat + 1'b1;
        end
      end

      S_WRITE: begin
        busy          = 1'b1;
        prod_wr_en    = 1'b1;
        prod_row_addr = row;
        prod_col_base = col_base;
        for (int k = 0; k < LANES; k++) begin
          prod_lane_mask[k] = (({1'b0, col_base} + CW1'(k)) < WCOLS_C);
        end
        if (prod_wr_ready) begin
          if (row != LAST_ROW) begin
            row_nxt   = row + 1'b1;
            state_nxt = S_READ_F;
          end else if (col_end >= WCOLS_C) begin
            state_nxt = S_DONE;
          end else begin
            row_nxt      = '0;
            col_base_nxt = COL_W'(col_end);
            state_nxt    = S_LOAD_W;
          end
        end
      end

      S_DONE: begin
        done = 1'b1;
        if (!start) state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Abort overrides every transition of a busy state, including a WRITE
    // transfer; outputs of this cycle stay Moore-decoded.
    if (abort_hit && busy) begin
      state_nxt    = S_IDLE;
      row_nxt      = '0;
      col_base_nxt = '0;
      lane_nxt     = '0;
      lat_nxt      = '0;
    end
  end

endmodule

// File: tb/tb_gcn_transform_ctrl.sv
// tb_gcn_transform_ctrl
//   Directed bench for gcn_transform_ctrl with FEATURE_ROWS=6, WEIGHT_COLS=3,
//   MAC_LATENCY=1 and three lane configurations (u1: LANES=1, u2: LANES=2,
//   u3: LANES=3). Inputs change and outputs are sampled on the falling edge.

`timescale 1ns/1ps

module tb_gcn_transform_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // ---------------- u1 : LANES=1 ----------------
  logic       s1, r1;
  logic       w1_en, sw1, f1_en, p1_en, busy1, done1;
  logic [1:0] w1_addr, p1_col;
  logic [0:0] sl1, p1_mask;
  logic [2:0] f1_addr, p1_row;

  // ---------------- u2 : LANES=2 ----------------
  logic       s2, r2;
  logic       w2_en, sw2, f2_en, p2_en, busy2, done2;
  logic [1:0] w2_addr, p2_col, p2_mask;
  logic [0:0] sl2;
  logic [2:0] f2_addr, p2_row;

  // ---------------- u3 : LANES=3 ----------------
  logic       s3, r3;
  logic       w3_en, sw3, f3_en, p3_en, busy3, done3;
  logic [1:0] w3_addr, p3_col, sl3;
  logic [2:0] f3_addr, p3_row, p3_mask;

`ifdef GCN_TRANSFORM_ABORT_EN
  logic a1, a2, a3;
`endif

  gcn_transform_ctrl #(.FEATURE_ROWS(6), .WEIGHT_COLS(3), .LANES(1), .MAC_LATENCY(1)) u1 (
    .clk(clk), .reset(reset),
`ifdef GCN_TRANSFORM_ABORT_EN
    .abort(a1),
`endif
    .start(s1), .prod_wr_ready(r1),
    .weight_rd_en(w1_en), .weight_col_addr(w1_addr),
    .scratch_we(sw1), .scratch_lane(sl1),
    .feature_rd_en(f1_en), .feature_row_addr(f1_addr),
    .prod_wr_en(p1_en), .prod_row_addr(p1_row), .prod_col_base(p1_col),
    .prod_lane_mask(p1_mask), .busy(busy1), .done(done1)
  );

  gcn_transform_ctrl #(.FEATURE_ROWS(6), .WEIGHT_COLS(3), .LANES(2), .MAC_LATENCY(1)) u2 (
    .clk(clk), .reset(reset),
`ifdef GCN_TRANSFORM_ABORT_EN
    .abort(a2),
`endif
    .start(s2), .prod_wr_ready(r2),
    .weight_rd_en(w2_en), .weight_col_addr(w2_addr),
    .scratch_we(sw2), .scratch_lane(sl2),
    .feature_rd_en(f2_en), .feature_row_addr(f2_addr),
    .prod_wr_en(p2_en), .prod_row_addr(p2_row), .prod_col_base(p2_col),
    .prod_lane_mask(p2_mask), .busy(busy2), .done(done2)
  );

  gcn_transform_ctrl #(.FEATURE_ROWS(6), .WEIGHT_COLS(3), .LANES(3), .MAC_LATENCY(1)) u3 (
    .clk(clk), .reset(reset),
`ifdef GCN_TRANSFORM_ABORT_EN
    .abort(a3),
`endif
    .start(s3), .prod_wr_ready(r3),
    .weight_rd_en(w3_en), .weight_col_addr(w3_addr),
    .scratch_we(sw3), .scratch_lane(sl3),
    .feature_rd_en(f3_en), .feature_row_addr(f3_addr),
    .prod_wr_en(p3_en), .prod_row_addr(p3_row), .prod_col_base(p3_col),
    .prod_lane_mask(p3_mask), .busy(busy3), .done(done3)
  );

  // ---------------- driver / checker tasks ----------------

  // All outputs of every instance must be zero while reset is held.
  task automatic test_reset();
    reset = 1'b1;
    s1 = 0; s2 = 0; s3 = 0; r1 = 1; r2 = 1; r3 = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({w1_en, w1_addr, sw1, sl1, f1_en, f1_addr, p1_en, p1_row, p1_col, p1_mask, busy1, done1} !== '0) begin
      fails++; $display("FAIL reset_u1: got outputs nonzero, required all 0");
    end
    checks++;
    if ({w2_en, w2_addr, sw2, sl2, f2_en, f2_addr, p2_en, p2_row, p2_col, p2_mask, busy2, done2} !== '0) begin
      fails++; $display("FAIL reset_u2: got outputs nonzero, required all 0");
    end
    checks++;
    if ({w3_en, w3_addr, sw3, sl3, f3_en, f3_addr, p3_en, p3_row, p3_col, p3_mask, busy3, done3} !== '0) begin
      fails++; $display("FAIL reset_u3: got outputs nonzero, required all 0");
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  // One full LANES=1 run on u1 with ready held high. Checks load order,
  // write order (col-major groups, rows 0..5), mask and the 57-cycle length.
  task automatic run_l1(input bit hold);
    logic [1:0] ld_q[$];
    logic [4:0] exp_q[$];
    logic [4:0] e;
    int cyc;
    bit fin;
    for (int c = 0; c < 3; c++) ld_q.push_back(2'(c));
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 6; r++) exp_q.push_back({3'(r), 2'(c)});
    s1 = 0; r1 = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      fails++; $display("FAIL l1_idle: got busy=%0b done=%0b required 0 0", busy1, done1);
    end
    s1 = 1;
    cyc = 0; fin = 0;
    for (int i = 0; i < 300 && !fin; i++) begin
      @(negedge clk);
      if (!hold) s1 = 0;
      if (done1) fin = 1;
      else begin
        if (busy1) cyc++;
        if (w1_en) begin
          checks++;
          if (ld_q.size() == 0) begin
            fails++; $display("FAIL l1_load_extra: got col %0d required none", w1_addr);
          end else if (w1_addr !== ld_q[0] || sw1 !== 1'b1 || sl1 !== 1'b0) begin
            fails++; $display("FAIL l1_load: got col %0d lane %0d we %0b required col %0d lane 0 we 1",
                              w1_addr, sl1, sw1, ld_q[0]);
          end
          if (ld_q.size() != 0) void'(ld_q.pop_front());
        end
        if (p1_en && r1) begin
          checks++;
          if (exp_q.size() == 0) begin
            fails++; $display("FAIL l1_write_extra: got row %0d col %0d required none", p1_row, p1_col);
          end else begin
            e = exp_q.pop_front();
            if ({p1_row, p1_col} !== e || p1_mask !== 1'b1) begin
              fails++; $display("FAIL l1_write: got row %0d col %0d mask %b required row %0d col %0d mask 1",
                                p1_row, p1_col, p1_mask, e[4:2], e[1:0]);
            end
          end
        end
      end
    end
    checks++;
    if (!fin) begin
      fails++; $display("FAIL l1_timeout: got no done, required done");
    end
    checks++;
    if (cyc != 57) begin
      fails++; $display("FAIL l1_cycles: got %0d required 57", cyc);
    end
    checks++;
    if (ld_q.size() != 0 || exp_q.size() != 0) begin
      fails++; $display("FAIL l1_missing: got %0d loads %0d writes left, required 0 0", ld_q.size(), exp_q.size());
    end
  endtask

  task automatic test_lanes1();
    run_l1(1'b0);
  endtask

  // LANES=2: group 0 loads cols 0,1 (mask 11), group 1 loads col 2 only (mask 01).
  task automatic test_lanes2();
    logic [2:0] ld_q[$];
    logic [6:0] exp_q[$];
    logic [6:0] e;
    int cyc;
    bit fin;
    ld_q.push_back(3'b000); ld_q.push_back(3'b011); ld_q.push_back(3'b100);
    for (int r = 0; r < 6; r++) exp_q.push_back({3'(r), 2'd0, 2'b11});
    for (int r = 0; r < 6; r++) exp_q.push_back({3'(r), 2'd2, 2'b01});
    r2 = 1;
    s2 = 1;
    cyc = 0; fin = 0;
    for (int i = 0; i < 300 && !fin; i++) begin
      @(negedge clk);
      s2 = 0;
      if (done2) fin = 1;
      else begin
        if (busy2) cyc++;
        if (w2_en) begin
          checks++;
          if (ld_q.size() == 0) begin
            fails++; $display("FAIL l2_load_extra: got col %0d lane %0d required none", w2_addr, sl2);
          end else if ({w2_addr, sl2} !== ld_q[0] || sw2 !== 1'b1) begin
            fails++; $display("FAIL l2_load: got col %0d lane %0d required col %0d lane %0d",
                              w2_addr, sl2, ld_q[0][2:1], ld_q[0][0]);
          end
          if (ld_q.size() != 0) void'(ld_q.pop_front());
        end
        if (p2_en && r2) begin
          checks++;
          if (exp_q.size() == 0) begin
            fails++; $display("FAIL l2_write_extra: got row %0d col %0d required none", p2_row, p2_col);
          end else begin
            e = exp_q.pop_front();
            if ({p2_row, p2_col, p2_mask} !== e) begin
              fails++; $display("FAIL l2_write: got row %0d col %0d mask %b required row %0d col %0d mask %b",
                                p2_row, p2_col, p2_mask, e[6:4], e[3:2], e[1:0]);
            end
          end
        end
      end
    end
    checks++;
    if (!fin || cyc != 39) begin
      fails++; $display("FAIL l2_cycles: got %0d (done=%0b) required 39", cyc, fin);
    end
    checks++;
    if (ld_q.size() != 0 || exp_q.size() != 0) begin
      fails++; $display("FAIL l2_missing: got %0d loads %0d writes left, required 0 0", ld_q.size(), exp_q.size());
    end
  endtask

  // LANES=3 with ready = 0,0,1 in each WRITE: outputs held, 6 transfers, rows 0..5.
  task automatic test_ready_toggle();
    logic [7:0] held;
    int wcnt, xfers, cyc, loads;
    bit fin;
    s3 = 1; r3 = 0;
    wcnt = 0; xfers = 0; cyc = 0; loads = 0; fin = 0; held = '0;
    for (int i = 0; i < 300 && !fin; i++) begin
      @(negedge clk);
      s3 = 0;
      if (done3) begin
        fin = 1; r3 = 0;
      end else begin
        if (busy3) cyc++;
        if (w3_en) begin
          checks++;
          if (w3_addr !== 2'(loads) || sl3 !== 2'(loads)) begin
            fails++; $display("FAIL l3_load: got col %0d lane %0d required %0d %0d", w3_addr, sl3, loads, loads);
          end
          loads++;
        end
        if (p3_en) begin
          if (wcnt == 0) begin
            held = {p3_row, p3_col, p3_mask};
            checks++;
            if (held !== {3'(xfers), 2'd0, 3'b111}) begin
              fails++; $display("FAIL l3_write: got row %0d col %0d mask %b required row %0d col 0 mask 111",
                                p3_row, p3_col, p3_mask, xfers);
            end
          end else begin
            checks++;
            if ({p3_row, p3_col, p3_mask} !== held) begin
              fails++; $display("FAIL l3_hold: got %h required %h", {p3_row, p3_col, p3_mask}, held);
            end
          end
          r3 = (wcnt == 2);
          if (r3) begin
            xfers++;
            wcnt = 0;
          end else begin
            wcnt++;
          end
        end else begin
          r3 = 0;
          wcnt = 0;
        end
      end
    end
    checks++;
    if (!fin || xfers != 6 || loads != 3) begin
      fails++; $display("FAIL l3_count: got xfers %0d loads %0d done %0b required 6 3 1", xfers, loads, fin);
    end
    checks++;
    if (cyc != 33) begin
      fails++; $display("FAIL l3_cycles: got %0d required 33", cyc);
    end
  endtask

  // start held through DONE: no retrigger; drop -> IDLE; rerun identical.
  task automatic test_start_held();
    run_l1(1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (done1 !== 1'b1 || busy1 !== 1'b0 || w1_en !== 1'b0) begin
        fails++; $display("FAIL held_done: got done %0b busy %0b wr %0b required 1 0 0", done1, busy1, w1_en);
      end
    end
    s1 = 0;
    @(negedge clk);
    checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      fails++; $display("FAIL held_release: got done %0b busy %0b required 0 0", done1, busy1);
    end
    run_l1(1'b0);
  endtask

  // Reset in WRITE at row 3, col 1 clears outputs immediately; rerun from 0,0.
  task automatic test_reset_mid_run();
    bit hit;
    s1 = 0; r1 = 1;
    repeat (2) @(negedge clk);
    s1 = 1;
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      s1 = 0;
      if (p1_en && p1_row == 3'd3 && p1_col == 2'd1) hit = 1;
    end
    checks++;
    if (!hit) begin
      fails++; $display("FAIL rst_mid_reach: got no WRITE row 3 col 1, required one");
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({w1_en, w1_addr, sw1, sl1, f1_en, f1_addr, p1_en, p1_row, p1_col, p1_mask, busy1, done1} !== '0) begin
      fails++; $display("FAIL rst_mid_outputs: got en %0b row %0d col %0d busy %0b required all 0",
                        p1_en, p1_row, p1_col, busy1);
    end
    @(negedge clk);
    reset = 1'b0;
    run_l1(1'b0);
  endtask

`ifdef GCN_TRANSFORM_ABORT_EN
  // Abort in MAC_WAIT of row 2 -> IDLE next cycle, no done; then a clean run.
  task automatic test_abort();
    bit hit, saw_done;
    s1 = 0; r1 = 1; a1 = 0;
    repeat (2) @(negedge clk);
    s1 = 1;
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      s1 = 0;
      if (f1_en && f1_addr == 3'd2) hit = 1;
    end
    @(negedge clk);
    checks++;
    if (!hit || busy1 !== 1'b1 || f1_en !== 1'b0 || p1_en !== 1'b0) begin
      fails++; $display("FAIL abort_reach: got hit %0b busy %0b required MAC_WAIT", hit, busy1);
    end
    a1 = 1;
    @(negedge clk);
    a1 = 0;
    checks++;
    if ({w1_en, w1_addr, sw1, sl1, f1_en, f1_addr, p1_en, p1_row, p1_col, p1_mask, busy1, done1} !== '0) begin
      fails++; $display("FAIL abort_idle: got busy %0b done %0b required 0 0", busy1, done1);
    end
    saw_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done1 || busy1) saw_done = 1;
    end
    checks++;
    if (saw_done) begin
      fails++; $display("FAIL abort_no_done: got activity after abort, required none");
    end
    run_l1(1'b0);
  endtask
`endif

  // ---------------- sequence ----------------
  initial begin
`ifdef GCN_TRANSFORM_ABORT_EN
    a1 = 0; a2 = 0; a3 = 0;
`endif
    test_reset();
    test_lanes1();
    test_lanes2();
    test_ready_toggle();
    test_start_held();
    test_reset_mid_run();
`ifdef GCN_TRANSFORM_ABORT_EN
    test_abort();
`endif
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
